mf_threshold_trigger: RTL and testbench
=======================================

Name: mf_threshold_trigger

Overview:
- Sits directly downstream of the systA matched-filter stage in the SURF trigger path.
- Consumes 8 signed matched-filter samples per clock and forms the absolute value of each, with saturation.
- Compares each magnitude against a programmable threshold, applies a programmable holdoff and emits timestamped trigger records over a valid/ready handshake.
- Also produces a periodic trigger-rate scaler for threshold servoing.

Parameters:
- NSAMP, 8, samples per clock.
- INBITS, 16, signed width of each matched-filter sample.
- TSBITS, 32, timestamp counter width.
- HOLDBITS, 8, holdoff counter width.
- SCALER_LOG2, 20, scaler gate length is 2^SCALER_LOG2 clocks.

Ports:
- clk_i  in  1  system clock; single clock domain.
- rst_ni  in  1  asynchronous, active-low reset.
- dat_i  in  NSAMP x INBITS  signed matched-filter outputs; index 0 is the earliest sample.
- thresh_i  in  INBITS-1  unsigned threshold; a sample hits when its magnitude is strictly greater.
- holdoff_i  in  HOLDBITS  cycles during which hits are suppressed after a trigger.
- trig_valid_o  out  1  trigger record valid.
- trig_ready_i  in  1  consumer accepts the record.
- trig_addr_o  out  3  lowest sample index that hit in the triggering cycle.
- trig_ts_o  out  TSBITS  timestamp of the cycle in which dat_i was sampled.
- drop_cnt_o  out  8  saturating count of dropped triggers.
- scaler_o  out  16  triggers counted in the last gate.
- scaler_valid_o  out  1  one-cycle pulse when scaler_o updates.

Behaviour:
- Reset (rst_ni low, asynchronous): every register and output goes to 0, including the timestamp counter, holdoff counter, drop count, scaler count and the gate counter.
- Timestamp counter ts:
  - Free-running and wraps modulo 2^TSBITS.
  - Reads 0 on the first rising edge after reset is released.
  - ts is pipelined alongside the data, so trig_ts_o equals the ts value on the edge where the triggering dat_i was sampled.
- Stage 1 (S1, registered):
  - mag[k] = |dat_i[k]|, width INBITS-1.
  - -2^(INBITS-1) saturates to 2^(INBITS-1)-1.
- Stage 2 (S2, registered):
  - hit[k] = mag[k] > thresh_i.
  - thresh_i is sampled on this edge; no shadowing.
- Stage 3 (S3, decision):
  - any = OR of hit; addr = priority encode of hit, lowest index wins.
  - fire = any AND hold_cnt == 0.
  - On fire: hold_cnt loads holdoff_i.
  - Otherwise, when hold_cnt != 0, hold_cnt decrements.
  - With holdoff_i = 0, hits in consecutive cycles each fire.
  - With holdoff_i = H, the next fire is possible no earlier than H+1 cycles later.
- Output register (single entry):
  - If fire and (trig_valid_o == 0, or trig_ready_i == 1 in this cycle): load addr/ts and set trig_valid_o = 1.
  - If fire and trig_valid_o == 1 and trig_ready_i == 0: the new record is dropped, drop_cnt_o increments (saturating at 255), and holdoff still starts.
  - Accept with no fire: trig_valid_o clears on the next edge.
  - trig_addr_o and trig_ts_o stay stable while trig_valid_o is high and not accepted.
- Latency: dat_i sampled on edge N gives trig_valid_o high after edge N+3 when the output register is free.
- Scaler:
  - The gate counter counts 0 .. 2^SCALER_LOG2-1.
  - Every fire (accepted or dropped) increments cnt, saturating at 0xFFFF.
  - On the last gate cycle, scaler_o <= cnt (including a fire in that same cycle), scaler_valid_o pulses for 1 cycle, and cnt clears to 0.
  - The first scaler_valid_o occurs 2^SCALER_LOG2 cycles after reset release.
- Reset mid-operation: a pending record is discarded, with no partial handshake. The consumer must treat rst_ni low as a flush.

Decomposition:
- Package pueo_trig_pkg holds:
  - NSAMP, MF_INBITS = 16;
  - typedef mf_vec_t = logic signed [NSAMP-1:0][MF_INBITS-1:0];
  - typedef trig_rec_t = struct {addr, ts}.
- Sub-module prio_enc8: combinational 8-to-3 lowest-index encoder with an any output. It is shared with the future beam-trigger stage.
- The abs/saturate logic stays inline.

Test Plan:
1. Reset: hold rst_ni low with random dat_i -> every output is 0. Release rst_ni -> first scaler_valid_o occurs exactly 2^SCALER_LOG2 cycles later (bench uses SCALER_LOG2=4, i.e. 16 cycles) with scaler_o=0.
2. Single impulse: thresh_i=500, holdoff_i=0, trig_ready_i=1; dat_i[5]=1000 for one cycle at ts=T -> trig_valid_o one cycle at T+3, trig_addr_o=5, trig_ts_o=T.
3. Simultaneous and negative hits: dat_i[2]=-2000 and dat_i[6]=2000 in the same cycle -> exactly one record, addr=2. dat_i[k]=500 with thresh_i=500 -> no trigger (strict compare).
4. Holdoff: holdoff_i=4; a hit on dat_i[0] in 7 consecutive cycles -> fires in cycles 0 and 5 only. Scaler (SCALER_LOG2=4) reports 2 for that gate.
5. Backpressure: trig_ready_i=0 with two hits 1 cycle apart, holdoff_i=0 -> first record held stable, second dropped, drop_cnt_o=1. Raise ready -> valid clears next edge.
6. Saturation: dat_i[7]=-32768 with thresh_i=32766 -> trigger, addr=7. Same input with thresh_i=32767 -> no trigger. 300 forced drops -> drop_cnt_o stays at 255.

Source files
------------

// File: rtl/pueo_trig_pkg.sv
// Shared types and constants for the PUEO/SURF trigger path.
package pueo_trig_pkg;

    localparam int NSAMP     = 8;
    localparam int MF_INBITS = 16;
    localparam int TS_BITS   = 32;
    localparam int ADDR_BITS = 3;

    typedef logic signed [NSAMP-1:0][MF_INBITS-1:0] mf_vec_t;

    typedef struct packed {
        logic [ADDR_BITS-1:0] addr;
        logic [TS_BITS-1:0]   ts;
    } trig_rec_t;

endpackage

// File: rtl/mf_threshold_trigger_if.sv
// Trigger-record valid/ready channel between the threshold trigger and its consumer.
interface mf_threshold_trigger_if #(
    parameter int TSBITS = pueo_trig_pkg::TS_BITS
);
    logic                                 trig_valid;
    logic                                 trig_ready;
    logic [pueo_trig_pkg::ADDR_BITS-1:0]  trig_addr;
    logic [TSBITS-1:0]                    trig_ts;

    modport master (output trig_valid, output trig_addr, output trig_ts, input  trig_ready);
    modport slave  (input  trig_valid, input  trig_addr, input  trig_ts, output trig_ready);
endinterface

// File: rtl/prio_enc8.sv
// Combinational 8-to-3 priority encoder; the lowest set index wins.
module prio_enc8 (
    input  logic [7:0] req_i,
    output logic       any_o,
    output logic [2:0] addr_o
);

    // lowest-index request selects the address
    always_comb begin
        any_o = |req_i;
        casez (req_i)
            8'b???????1: addr_o = 3'd0;
            8'b??????10: addr_o = 3'd1;
            8'b?????100: addr_o = 3'd2;
            8'b????1000: addr_o = 3'd3;
            8'b???10000: addr_o = 3'd4;
            8'b??100000: addr_o = 3'd5;
            8'b?1000000: addr_o = 3'd6;
            8'b10000000: addr_o = 3'd7;
            default:     addr_o = 3'd0;
        endcase
    end

endmodule

// File: rtl/mf_threshold_trigger.sv
// Magnitude threshold trigger on matched-filter samples: abs/compare pipeline,
// holdoff, single-entry timestamped record output and a gated trigger-rate scaler.
module mf_threshold_trigger
    import pueo_trig_pkg::*;
#(
    parameter int INBITS      = MF_INBITS,
    parameter int TSBITS      = 32,
    parameter int HOLDBITS    = 8,
    parameter int SCALER_LOG2 = 20
) (
    input  logic                                clk_i,
    input  logic                                rst_ni,
    input  logic signed [NSAMP-1:0][INBITS-1:0] dat_i,
    input  logic [INBITS-2:0]                   thresh_i,
    input  logic [HOLDBITS-1:0]                 holdoff_i,
    mf_threshold_trigger_if.master              trig,
    output logic [7:0]                          drop_cnt_o,
    output logic [15:0]                         scaler_o,
    output logic                                scaler_valid_o
);

    localparam int MAGBITS = INBITS - 1;
    localparam logic [HOLDBITS-1:0]    HOLD_ZERO = {HOLDBITS{1'b0}};
    localparam logic [HOLDBITS-1:0]    HOLD_ONE  = {{(HOLDBITS-1){1'b0}}, 1'b1};
    localparam logic [SCALER_LOG2-1:0] GATE_LAST = {SCALER_LOG2{1'b1}};
    localparam logic [SCALER_LOG2-1:0] GATE_ONE  = {{(SCALER_LOG2-1){1'b0}}, 1'b1};
    localparam logic [TSBITS-1:0]      TS_ONE    = {{(TSBITS-1){1'b0}}, 1'b1};

    // Only the most negative code overflows on negation; it clamps to full scale.
    function automatic logic [MAGBITS-1:0] abs_sat(input logic [INBITS-1:0] x);
        logic [INBITS-1:0] neg;
        neg = ~x + {{(INBITS-1){1'b0}}, 1'b1};
        if (!x[INBITS-1])       abs_sat = x[MAGBITS-1:0];
        else if (neg[INBITS-1]) abs_sat = {MAGBITS{1'b1}};
        else                    abs_sat = neg[MAGBITS-1:0];
    endfunction

    logic [TSBITS-1:0]              ts_q, ts_d;
    logic [NSAMP-1:0][MAGBITS-1:0]  s1_mag_q, s1_mag_d;
    logic [TSBITS-1:0]              s1_ts_q, s2_ts_q, s3_ts_q;
    logic [NSAMP-1:0]               s2_hit_q, s2_hit_d;
    logic                           enc_any_s, s3_any_q;
    logic [2:0]                     enc_addr_s, s3_addr_q;
    logic                           fire_s;
    logic [HOLDBITS-1:0]            hold_q, hold_d;
    logic                           valid_q, valid_d;
    logic [2:0]                     addr_q, addr_d;
    logic [TSBITS-1:0]              rts_q, rts_d;
    logic [7:0]                     drop_q, drop_d;
    logic [SCALER_LOG2-1:0]         gate_q, gate_d;
    logic [15:0]                    cnt_q, cnt_d, cnt_inc_s, scaler_q, scaler_d;
    logic                           sv_q, sv_d;

    // timestamp increment, magnitude and threshold compare
    always_comb begin
        ts_d = ts_q + TS_ONE;
        for (int k = 0; k < NSAMP; k++) begin
            s1_mag_d[k] = abs_sat(dat_i[k]);
            s2_hit_d[k] = (s1_mag_q[k] > thresh_i);
        end
    end

    prio_enc8 u_prio_enc8 (
        .req_i  (s2_hit_q),
        .any_o  (enc_any_s),
        .addr_o (enc_addr_s)
    );

    // pipeline registers; the timestamp travels with its data
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            ts_q      <= '0;
            s1_mag_q  <= '0;
            s1_ts_q   <= '0;
            s2_hit_q  <= '0;
            s2_ts_q   <= '0;
            s3_any_q  <= 1'b0;
            s3_addr_q <= 3'd0;
            s3_ts_q   <= '0;
        end else begin
            ts_q      <= ts_d;
            s1_mag_q  <= s1_mag_d;
            s1_ts_q   <= ts_q;
            s2_hit_q  <= s2_hit_d;
            s2_ts_q   <= s1_ts_q;
            s3_any_q  <= enc_any_s;
            s3_addr_q <= enc_addr_s;
            s3_ts_q   <= s2_ts_q;
        end
    end

    assign fire_s = s3_any_q && (hold_q == HOLD_ZERO);

    // holdoff, single-entry output register and drop counting
    always_comb begin
        valid_d = valid_q;
        addr_d  = addr_q;
        rts_d   = rts_q;
        drop_d  = drop_q;
        if (fire_s) begin
            hold_d = holdoff_i;
        end else if (hold_q != HOLD_ZERO) begin
            hold_d = hold_q - HOLD_ONE;
        end else begin
            hold_d = hold_q;
        end
        if (fire_s && (!valid_q || trig.trig_ready)) begin
            valid_d = 1'b1;
            addr_d  = s3_addr_q;
            rts_d   = s3_ts_q;
        end else if (fire_s) begin
            if (drop_q != 8'hFF) drop_d = drop_q + 8'd1;
            else                 drop_d = drop_q;
        end else if (trig.trig_ready) begin
            valid_d = 1'b0;
        end else begin
            valid_d = valid_q;
        end
    end

    // scaler gate: a fire on the last gate cycle still lands in this gate's count
    always_comb begin
        gate_d = gate_q + GATE_ONE;
        if (fire_s && (cnt_q != 16'hFFFF)) cnt_inc_s = cnt_q + 16'd1;
        else                               cnt_inc_s = cnt_q;
        if (gate_q == GATE_LAST) begin
            scaler_d = cnt_inc_s;
            sv_d     = 1'b1;
            cnt_d    = 16'd0;
        end else begin
            scaler_d = scaler_q;
            sv_d     = 1'b0;
            cnt_d    = cnt_inc_s;
        end
    end

    // control state registers
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            hold_q   <= '0;
            valid_q  <= 1'b0;
            addr_q   <= 3'd0;
            rts_q    <= '0;
            drop_q   <= 8'd0;
            gate_q   <= '0;
            cnt_q    <= 16'd0;
            scaler_q <= 16'd0;
            sv_q     <= 1'b0;
        end else begin
            hold_q   <= hold_d;
            valid_q  <= valid_d;
            addr_q   <= addr_d;
            rts_q    <= rts_d;
            drop_q   <= drop_d;
            gate_q   <= gate_d;
            cnt_q    <= cnt_d;
            scaler_q <= scaler_d;
            sv_q     <= sv_d;
        end
    end

    assign trig.trig_valid = valid_q;
    assign trig.trig_addr  = addr_q;
    assign trig.trig_ts    = rts_q;
    assign drop_cnt_o      = drop_q;
    assign scaler_o        = scaler_q;
    assign scaler_valid_o  = sv_q;

endmodule

// File: tb/tb_mf_threshold_trigger.sv
// Self-checking bench for mf_threshold_trigger: directed vectors plus a random run
// against a transaction-level reference model.
module tb_mf_threshold_trigger;
    import pueo_trig_pkg::*;

    localparam int SL = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    mf_vec_t     dat;
    logic [14:0] thr;
    logic [7:0]  hold;
    logic [7:0]  drop;
    logic [15:0] scaler;
    logic        sv;

    mf_threshold_trigger_if #(.TSBITS(32)) trig_if ();

    mf_threshold_trigger #(
        .INBITS(16), .TSBITS(32), .HOLDBITS(8), .SCALER_LOG2(SL)
    ) dut (
        .clk_i          (clk),
        .rst_ni         (rst_n),
        .dat_i          (dat),
        .thresh_i       (thr),
        .holdoff_i      (hold),
        .trig           (trig_if),
        .drop_cnt_o     (drop),
        .scaler_o       (scaler),
        .scaler_valid_o (sv)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string name, input longint act, input longint exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, want %0d", name, act, exp);
        end
    endtask

    // ---------------- reference model ----------------
    typedef struct packed {
        logic      any;
        trig_rec_t rec;
    } cand_t;

    cand_t     m_q[$];
    int        m_e;
    longint    m_next_ok;
    mf_vec_t   m_prev_dat;
    int        m_prev_ts;
    bit        m_valid;
    trig_rec_t m_out;
    int        m_drop, m_cnt, m_scaler;
    bit        m_sv;

    function automatic int mag_of(input logic [15:0] x);
        int v;
        v = int'($signed(x));
        if (v < 0) v = -v;
        if (v > 32767) v = 32767;
        return v;
    endfunction

    task automatic model_reset();
        m_q = {};
        m_q.push_back('0);
        m_q.push_back('0);
        m_e = 0; m_next_ok = 0; m_prev_dat = '0; m_prev_ts = 0;
        m_valid = 0; m_out = '0; m_drop = 0; m_cnt = 0; m_scaler = 0; m_sv = 0;
    endtask

    // one clock edge: decide on the candidate seen three edges after its data
    task automatic model_edge();
        cand_t c, n;
        bit    fire;
        int    period;
        period = 1 << SL;
        c = m_q.pop_front();
        fire = c.any && (longint'(m_e) >= m_next_ok);
        if (fire) m_next_ok = longint'(m_e) + longint'(hold) + 1;
        if (fire && (!m_valid || trig_if.trig_ready)) begin
            m_valid = 1; m_out = c.rec;
        end else if (fire) begin
            if (m_drop < 255) m_drop++;
        end else if (trig_if.trig_ready) begin
            m_valid = 0;
        end
        if (fire && m_cnt < 65535) m_cnt++;
        if (m_e % period == period - 1) begin
            m_scaler = m_cnt; m_sv = 1; m_cnt = 0;
        end else begin
            m_sv = 0;
        end
        n = '0;
        for (int k = 0; k < NSAMP; k++)
            if (!n.any && mag_of(m_prev_dat[k]) > int'(thr)) begin
                n.any = 1'b1;
                n.rec.addr = 3'(k);
            end
        n.rec.ts = 32'(m_prev_ts);
        m_q.push_back(n);
        m_prev_dat = dat;
        m_prev_ts  = m_e;
        m_e++;
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
        chk("valid", trig_if.trig_valid, m_valid);
        if (m_valid) begin
            chk("addr", trig_if.trig_addr, m_out.addr);
            chk("ts", trig_if.trig_ts, m_out.ts);
        end
        chk("drop", drop, m_drop);
        chk("scaler_valid", sv, m_sv);
        chk("scaler", scaler, m_scaler);
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_valid"}, trig_if.trig_valid, 0);
        chk({tag, "_addr"}, trig_if.trig_addr, 0);
        chk({tag, "_ts"}, trig_if.trig_ts, 0);
        chk({tag, "_drop"}, drop, 0);
        chk({tag, "_scaler"}, scaler, 0);
        chk({tag, "_sv"}, sv, 0);
    endtask

    task automatic reset_dut();
        @(negedge clk);
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        model_reset();
    endtask

    // ---------------- directed vector table ----------------
    typedef struct {
        int ia; int va; int ib; int vb; int th; bit fire; int addr;
    } vec_t;
    vec_t tbl[8];

    task automatic run_vec(input vec_t v, input int idx);
        int t0;
        thr = 15'(v.th); hold = 8'd0; trig_if.trig_ready = 1'b1; dat = '0;
        repeat (5) step();
        dat[v.ia] = 16'(v.va);
        dat[v.ib] = 16'(v.vb);
        t0 = m_e;
        step();
        dat = '0;
        repeat (3) step();
        chk($sformatf("vec%0d_valid", idx), trig_if.trig_valid, v.fire);
        if (v.fire) begin
            chk($sformatf("vec%0d_addr", idx), trig_if.trig_addr, v.addr);
            chk($sformatf("vec%0d_ts", idx), trig_if.trig_ts, t0);
        end
        step();
        chk($sformatf("vec%0d_clear", idx), trig_if.trig_valid, 0);
    endtask

    initial begin
        int ts_a[$];
        int t0;

        tbl[0] = '{5,  1000,   0,    0, 500,   1'b1, 5};
        tbl[1] = '{2, -2000,   6, 2000, 500,   1'b1, 2};
        tbl[2] = '{3,   500,   0,    0, 500,   1'b0, 0};
        tbl[3] = '{3,   501,   0,    0, 500,   1'b1, 3};
        tbl[4] = '{7, -32768,  0,    0, 32766, 1'b1, 7};
        tbl[5] = '{7, -32768,  0,    0, 32767, 1'b0, 0};
        tbl[6] = '{0,  -501,   1, -500, 500,   1'b1, 0};
        tbl[7] = '{4, 32767,   6,  400, 32767, 1'b0, 0};

        dat = '0; thr = 15'd500; hold = 8'd0; trig_if.trig_ready = 1'b0;

        // reset with random data on the inputs, then the first scaler gate
        for (int i = 0; i < 5; i++) begin
            for (int k = 0; k < NSAMP; k++) dat[k] = 16'($urandom);
            @(negedge clk);
            chk_all_zero("rst");
        end
        rst_n = 1'b1;
        model_reset();
        dat = '0;
        for (int i = 0; i < 16; i++) begin
            step();
            chk("first_gate_sv", sv, (i == 15) ? 1 : 0);
        end
        chk("first_gate_scaler", scaler, 0);

        // holdoff of 4 over seven consecutive hits
        reset_dut();
        thr = 15'd500; hold = 8'd4; trig_if.trig_ready = 1'b1;
        for (int i = 0; i < 16; i++) begin
            dat = '0;
            if (i < 7) dat[0] = 16'sd1000;
            step();
            if (trig_if.trig_valid) ts_a.push_back(int'(trig_if.trig_ts));
        end
        chk("hold_nrec", ts_a.size(), 2);
        chk("hold_ts0", (ts_a.size() > 0) ? ts_a[0] : -1, 0);
        chk("hold_ts1", (ts_a.size() > 1) ? ts_a[1] : -1, 5);
        chk("hold_scaler_sv", sv, 1);
        chk("hold_scaler", scaler, 2);

        for (int i = 0; i < 8; i++) run_vec(tbl[i], i);

        // backpressure: second record dropped, first held stable
        trig_if.trig_ready = 1'b0; hold = 8'd0; thr = 15'd500; dat = '0;
        repeat (3) step();
        dat[1] = 16'sd1000;
        t0 = m_e;
        step();
        dat = '0; dat[2] = 16'sd1000;
        step();
        dat = '0;
        repeat (2) step();
        chk("bp_valid", trig_if.trig_valid, 1);
        chk("bp_addr", trig_if.trig_addr, 1);
        chk("bp_ts", trig_if.trig_ts, t0);
        repeat (4) step();
        chk("bp_hold_addr", trig_if.trig_addr, 1);
        chk("bp_hold_ts", trig_if.trig_ts, t0);
        chk("bp_drop", drop, 1);
        trig_if.trig_ready = 1'b1;
        step();
        chk("bp_clear", trig_if.trig_valid, 0);

        // drop counter saturation
        trig_if.trig_ready = 1'b0;
        dat = '0; dat[0] = 16'sd1000;
        repeat (305) step();
        chk("drop_sat", drop, 255);
        chk("drop_sat_valid", trig_if.trig_valid, 1);

        // asynchronous reset while a record is pending
        rst_n = 1'b0;
        #1;
        chk_all_zero("midrst");
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        model_reset();

        // randomized run against the model
        for (int i = 0; i < 3000; i++) begin
            if (i % 150 == 0)
                thr = ($urandom_range(0, 9) == 0) ? 15'd32766 : 15'($urandom_range(300, 3000));
            hold = 8'($urandom_range(0, 6));
            trig_if.trig_ready = ($urandom_range(0, 3) != 0);
            for (int k = 0; k < NSAMP; k++)
                dat[k] = ($urandom_range(0, 39) == 0) ? 16'($urandom)
                                                      : 16'(int'($urandom_range(0, 600)) - 300);
            step();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
